opl3_fpga_axi_regs: RTL

AXI4-Lite slave register file that terminates the host register path of the OPL3 FPGA IP. It responds to single-beat read and write transactions from the processing system (or the AXI4-Lite master BFM in simulation) against four 32-bit registers. It exports the register contents, plus a one-cycle commit pulse per register, to the OPL3 core. Every transaction completes with an OKAY response.

---
 rtl/opl3_fpga_axi_regs.sv | 121 ++++++++++++
 1 files changed

// File: rtl/opl3_fpga_axi_regs.sv
// AXI4-Lite slave holding the four 32-bit OPL3 host registers.
// Exports register contents and a one-cycle commit pulse per register to the core.
module opl3_fpga_axi_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
   output logic [3:0]                      reg_wr_pulse
);

   localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

   logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
   logic                          aw_full;
   logic                          w_full;
   logic [1:0]                    aw_sel;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
   logic [STRB_W-1:0]             w_strb;

   logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic       aw_full_nx, w_full_nx, bvalid_nx, rvalid_nx, commit_set;
   logic [1:0] aw_sel_nx;

   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign S_AXI_BRESP = 2'b00;
   assign S_AXI_RRESP = 2'b00;
   assign slv_reg0    = regs[0];
   assign slv_reg1    = regs[1];
   assign slv_reg2    = regs[2];
   assign slv_reg3    = regs[3];

   // NOTE: every always_comb output is assigned on every path, so no latch is inferred;
   // combinational logic uses blocking '=', the flops below use non-blocking '<='.
   always_comb begin
      aw_hs      = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs       = S_AXI_WVALID  && S_AXI_WREADY;
      b_hs       = S_AXI_BVALID  && S_AXI_BREADY;
      ar_hs      = S_AXI_ARVALID && S_AXI_ARREADY;
      r_hs       = S_AXI_RVALID  && S_AXI_RREADY;
      aw_full_nx = (aw_full && !b_hs) || aw_hs;
      w_full_nx  = (w_full  && !b_hs) || w_hs;
      aw_sel_nx  = aw_hs ? S_AXI_AWADDR[3:2] : aw_sel;
      // Both halves present and no response outstanding: pulse and BVALID go out next cycle.
      commit_set = aw_full_nx && w_full_nx && !S_AXI_BVALID;
      bvalid_nx  = commit_set || (S_AXI_BVALID && !b_hs);
      rvalid_nx  = ar_hs || (S_AXI_RVALID && !r_hs);
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         aw_full       <= 1'b0;
         w_full        <= 1'b0;
         aw_sel        <= '0;
         w_data        <= '0;
         w_strb        <= '0;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         reg_wr_pulse  <= '0;
         // NOTE: the register array is small and its contents are architecturally
         // visible after reset, so it is cleared here rather than left unreset.
         for (int r = 0; r < 4; r++) regs[r] <= '0;
      end else begin
         aw_full       <= aw_full_nx;
         w_full        <= w_full_nx;
         aw_sel        <= aw_sel_nx;
         if (w_hs) begin
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         S_AXI_BVALID  <= bvalid_nx;
         S_AXI_AWREADY <= !aw_full_nx && !bvalid_nx;
         S_AXI_WREADY  <= !w_full_nx && !bvalid_nx;
         reg_wr_pulse  <= commit_set ? (4'b0001 << aw_sel_nx) : 4'b0000;

         // The array updates at the end of the pulse cycle, so a read accepted in
         // that same cycle still returns the pre-commit value.
         for (int r = 0; r < 4; r++) begin
            if (reg_wr_pulse[r]) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (w_strb[b]) regs[r][8*b +: 8] <= w_data[8*b +: 8];
               end
            end
         end

         S_AXI_ARREADY <= !rvalid_nx;
         S_AXI_RVALID  <= rvalid_nx;
         if (ar_hs) S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
      end
   end

endmodule
